clk_gate_idle_ctrl: RTL and testbench

Upstream controller for the asynchronous clock-gate stage. It decides when the downstream gated clock must run and drives the gate's asynchronous enable. It then waits for the gate's enable acknowledge, sampled asynchronously through its own synchronizer, before reporting the clock as on or off. It gates the clock automatically after a programmable run of idle cycles and re-enables it on activity or a wake pulse. An acknowledge watchdog flags a gate that never answers.

---
 rtl/clk_gate_ctrl_pkg.sv | 21 ++
 rtl/clk_gate_idle_ctrl_sync.sv | 37 +++
 rtl/clk_gate_idle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clk_gate_idle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl_pkg
// Shared types for the clock-gate idle controller.
//   state_e          : controller FSM state encoding
//   is_handshake()   : true in the states where an enable/ack handshake with
//                      the clock gate is in flight (WAKING, SLEEPING)
// -----------------------------------------------------------------------------
package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF      = 2'd0,
      WAKING   = 2'd1,
      ON       = 2'd2,
      SLEEPING = 2'd3
   } state_e;

   function automatic logic is_handshake(input state_e s);
      return (s == WAKING) || (s == SLEEPING);
   endfunction

endpackage

// File: rtl/clk_gate_idle_ctrl_sync.sv
// -----------------------------------------------------------------------------
// sync
// Multi-flop synchronizer for a single asynchronous level.
// Parameters:
//   STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk_i  : destination clock
//   rstn_i : asynchronous active-low reset, chain resets to 0
//   d_i    : asynchronous input level
//   q_o    : synchronized level, STAGES destination cycles behind d_i
// -----------------------------------------------------------------------------
module sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync: STAGES must be >= 2");
   end

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/clk_gate_idle_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_idle_ctrl
// Upstream controller for an asynchronous clock-gate stage. Requests the
// downstream clock on activity, waits for the gate's acknowledge (through a
// local synchronizer) before reporting ON, and gates the clock again after
// IDLE_CYCLES idle cycles. A watchdog flags a handshake that never completes.
// Parameters:
//   IDLE_CYCLES : idle cycles spent in ON before requesting clock-off (>= 1)
//   SYNC_STAGES : flops in the en_ack_i synchronizer (>= 2)
//   ACK_TIMEOUT : cycles in WAKING/SLEEPING without ack before err_o (>= 1)
// Ports:
//   clk_i      : controller clock
//   rstn_i     : asynchronous active-low reset
//   busy_i     : consumer has work (level)
//   wake_req_i : single-cycle wake pulse
//   force_on_i : hold the clock on, inhibit idle gating (level)
//   en_async_o : registered enable to the gate's asynchronous enable input
//   en_ack_i   : acknowledge from the gate, asynchronous to clk_i
//   clk_on_o   : high only in ON
//   busy_o     : high while a handshake is in flight
//   err_o      : sticky acknowledge-timeout flag
//   clr_err_i  : pulse, clears err_o (a coincident set wins)
// -----------------------------------------------------------------------------
module clk_gate_idle_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int IDLE_CYCLES = 16,
   parameter int SYNC_STAGES = 2,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic busy_i,
   input  logic wake_req_i,
   input  logic force_on_i,
   output logic en_async_o,
   input  logic en_ack_i,
   output logic clk_on_o,
   output logic busy_o,
   output logic err_o,
   input  logic clr_err_i
);

   if (IDLE_CYCLES < 1) begin : g_bad_idle
      $error("clk_gate_idle_ctrl: IDLE_CYCLES must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("clk_gate_idle_ctrl: SYNC_STAGES must be >= 2");
   end
   if (ACK_TIMEOUT < 1) begin : g_bad_tmo
      $error("clk_gate_idle_ctrl: ACK_TIMEOUT must be >= 1");
   end

   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

   localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ACK_TIMEOUT);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

   state_e            state_q, state_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              en_q, en_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;

   logic ack_s;
   logic act_now;
   logic act;
   logic enter_hs;
   logic err_set;

   sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (en_ack_i),
      .q_o    (ack_s)
   );

   // Direct activity reloads the idle counter in ON; the latched wake only
   // matters for leaving OFF/SLEEPING.
   assign act_now = busy_i | force_on_i | wake_req_i;
   assign act     = act_now | pend_q;

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      unique case (state_q)
         OFF: begin
            if (act) state_d = WAKING;
         end
         WAKING: begin
            if (ack_s) begin
               state_d = ON;
               idle_d  = IDLE_LOAD;
            end
         end
         ON: begin
            if (act_now) begin
               idle_d = IDLE_LOAD;
            end else if (idle_q > IDLE_ONE) begin
               idle_d = idle_q - IDLE_ONE;
            end else begin
               state_d = SLEEPING;
            end
         end
         SLEEPING: begin
            // Handshake is never aborted: wait for the gate to drop ack first.
            if (!ack_s) state_d = act ? WAKING : OFF;
         end
         default: state_d = OFF;
      endcase
   end

   // Enable is registered from the next state so it changes on the same edge
   // as the state entering WAKING/ON or leaving to SLEEPING/OFF.
   assign en_d = (state_d == WAKING) || (state_d == ON);

   // A wake pulse seen while the clock cannot immediately respond is kept
   // until the next entry to WAKING consumes it.
   always_comb begin
      pend_d = pend_q;
      if ((state_d == WAKING) && (state_q != WAKING)) begin
         pend_d = 1'b0;
      end else if (wake_req_i && ((state_q == OFF) || (state_q == SLEEPING))) begin
         pend_d = 1'b1;
      end
   end

   assign enter_hs = is_handshake(state_d) && (state_d != state_q);

   always_comb begin
      tmo_d = tmo_q;
      if (enter_hs) begin
         tmo_d = '0;
      end else if (is_handshake(state_q) && (tmo_q != TMO_MAX)) begin
         tmo_d = tmo_q + TMO_ONE;
      end
   end

   // Set only on the cycle the counter reaches the limit while still waiting,
   // so a later clear is not overridden by the saturated count.
   assign err_set = is_handshake(state_q) && (state_d == state_q) && (tmo_q == TMO_LAST);

   always_comb begin
      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (clr_err_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= OFF;
         idle_q  <= '0;
         tmo_q   <= '0;
         en_q    <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         tmo_q   <= tmo_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign en_async_o = en_q;
   assign clk_on_o   = (state_q == ON);
   assign busy_o     = is_handshake(state_q);
   assign err_o      = err_q;

endmodule

// File: tb/tb_clk_gate_idle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_idle_ctrl
// Directed bench for clk_gate_idle_ctrl with default parameters
// (IDLE_CYCLES=16, SYNC_STAGES=2, ACK_TIMEOUT=64). A gate model echoes
// en_async_o back on en_ack_i two clocks later; "mute" silences it.
// Outputs are observed as {en_async_o, clk_on_o, busy_o, err_o}.
// -----------------------------------------------------------------------------
module tb_clk_gate_idle_ctrl;

   localparam logic [3:0] E_OFF = 4'b0000;
   localparam logic [3:0] E_WAK = 4'b1010;
   localparam logic [3:0] E_ON  = 4'b1100;
   localparam logic [3:0] E_SLP = 4'b0010;
   localparam logic [3:0] E_ERR = 4'b0001;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic busy = 1'b0;
   logic wake = 1'b0;
   logic force_on = 1'b0;
   logic clr = 1'b0;
   logic mute = 1'b0;
   logic ack;
   logic en, clk_on, bsy_o, err;
   logic g1, g2;
   logic [3:0] obs;
   logic [3:0] exp_v;

   int n_vec = 0;
   int n_err = 0;

   assign obs = {en, clk_on, bsy_o, err};

   always #5 clk = ~clk;

   // Gate model: acknowledge follows enable with a two-clock delay and is
   // reset by the same reset as the controller.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         g1 <= 1'b0;
         g2 <= 1'b0;
      end else begin
         g1 <= en;
         g2 <= g1;
      end
   end
   assign ack = g2 & ~mute;

   clk_gate_idle_ctrl dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .busy_i     (busy),
      .wake_req_i (wake),
      .force_on_i (force_on),
      .en_async_o (en),
      .en_ack_i   (ack),
      .clk_on_o   (clk_on),
      .busy_o     (bsy_o),
      .err_o      (err),
      .clr_err_i  (clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      busy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_vec++;
         if (obs !== E_OFF) begin
            n_err++;
            $display("FAIL reset c=%0d obs=%b exp=%b", c, obs, E_OFF);
         end
      end
   endtask

   // busy held high across reset release: WAKING on edge 1, ON on edge 6.
   task automatic test_wake_from_reset();
      #2 rstn = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         exp_v = (c < 6) ? E_WAK : E_ON;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wake_from_reset c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
   endtask

   // From ON with busy just sampled high: 15 more ON cycles, SLEEPING on the
   // 16th edge, OFF five edges later once the ack has fallen through the sync.
   task automatic test_idle_gate();
      step();
      busy = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         step();
         exp_v = (c < 16) ? E_ON : (c < 21) ? E_SLP : E_OFF;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL idle_gate c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_wake_in_sleep();
      busy = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         exp_v = (c < 6) ? E_WAK : E_ON;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wis_up c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      busy = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         step();
         exp_v = (c < 16) ? E_ON : E_SLP;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wis_idle c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      // Pulse wake in SLEEPING: handshake completes, then WAKING (not OFF).
      wake = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         wake = 1'b0;
         exp_v = (c < 5) ? E_SLP : E_WAK;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wis_sleep c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      for (int c = 1; c <= 5; c++) begin
         step();
         exp_v = (c < 5) ? E_WAK : E_ON;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wis_rewake c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      // The pending wake was consumed: the next idle-out must settle in OFF.
      for (int c = 1; c <= 30; c++) begin
         step();
         exp_v = (c < 16) ? E_ON : (c < 21) ? E_SLP : E_OFF;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wis_pend_clear c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_force_on();
      force_on = 1'b1;
      for (int c = 1; c <= 106; c++) begin
         step();
         exp_v = (c < 6) ? E_WAK : E_ON;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL force_on c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      force_on = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         step();
         exp_v = (c < 16) ? E_ON : (c < 21) ? E_SLP : E_OFF;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL force_release c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
   endtask

   // Gate muted: err_o on the 64th edge after entering WAKING. A clear held
   // on that same edge loses to the set; a later clear pulse wins.
   task automatic test_ack_timeout();
      mute = 1'b1;
      wake = 1'b1;
      step();
      wake = 1'b0;
      n_vec++;
      if (obs !== E_WAK) begin
         n_err++;
         $display("FAIL tmo_enter obs=%b exp=%b", obs, E_WAK);
      end
      for (int c = 1; c <= 70; c++) begin
         step();
         clr = (c == 63);
         exp_v = (c < 64) ? E_WAK : (E_WAK | E_ERR);
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL ack_timeout c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_vec++;
      if (obs !== E_WAK) begin
         n_err++;
         $display("FAIL clr_err obs=%b exp=%b", obs, E_WAK);
      end
      step();
      n_vec++;
      if (obs !== E_WAK) begin
         n_err++;
         $display("FAIL clr_err_hold obs=%b exp=%b", obs, E_WAK);
      end
   endtask

   // Reset asserted between edges while WAKING, then a clean re-handshake.
   task automatic test_reset_waking();
      #2 rstn = 1'b0;
      #1;
      n_vec++;
      if (obs !== E_OFF) begin
         n_err++;
         $display("FAIL rst_waking obs=%b exp=%b", obs, E_OFF);
      end
      mute = 1'b0;
      busy = 1'b1;
      #2 rstn = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         exp_v = (c < 6) ? E_WAK : E_ON;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_waking_rewake c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
   endtask

   // Reset asserted between edges while SLEEPING, then OFF and a clean wake.
   task automatic test_reset_sleeping();
      busy = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         step();
         exp_v = (c < 16) ? E_ON : E_SLP;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_sleep_pre c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      #2 rstn = 1'b0;
      #1;
      n_vec++;
      if (obs !== E_OFF) begin
         n_err++;
         $display("FAIL rst_sleeping obs=%b exp=%b", obs, E_OFF);
      end
      step();
      n_vec++;
      if (obs !== E_OFF) begin
         n_err++;
         $display("FAIL rst_sleeping_held obs=%b exp=%b", obs, E_OFF);
      end
      #2 rstn = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         n_vec++;
         if (obs !== E_OFF) begin
            n_err++;
            $display("FAIL rst_sleep_off c=%0d obs=%b exp=%b", c, obs, E_OFF);
         end
      end
      busy = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         exp_v = (c < 6) ? E_WAK : E_ON;
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_sleep_rewake c=%0d obs=%b exp=%b", c, obs, exp_v);
         end
      end
      busy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wake_from_reset();
      test_idle_gate();
      test_wake_in_sleep();
      test_force_on();
      test_ack_timeout();
      test_reset_waking();
      test_reset_sleeping();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
